// File: rtl/riscv_pipe_pkg.sv
// ---------------------------------------------------------------
// riscv_pipe_pkg : shared pipeline widths, PC defaults, FSM states
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

package riscv_pipe_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEF_RESET_PC    = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_TRAP_VECTOR = 32'h0000_0100;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// ---------------------------------------------------------------
// sat_counter : W-bit up counter that sticks at all-ones
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------
// pc_redirect_ctrl : fetch PC generator with redirect, stall, trap
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module pc_redirect_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_tgt_i,
  output logic [31:0]      pc_o,
  output logic             pc_valid_o,
  output logic             flush_fd_o,
  output logic             flush_de_o,
  output logic             trap_o,
  output logic [31:0]      bad_addr_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  pc_state_e   state;
  pc_state_e   next_state;
  logic [31:0] next_pc;
  logic        next_valid;
  logic        next_trap;
  logic [31:0] next_bad;
  logic        accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pc_o       <= RESET_PC;
      pc_valid_o <= 1'b0;
      trap_o     <= 1'b0;
      bad_addr_o <= '0;
    end else begin
      state      <= next_state;
      pc_o       <= next_pc;
      pc_valid_o <= next_valid;
      trap_o     <= next_trap;
      bad_addr_o <= next_bad;
    end
  end

  always_comb begin
    next_state = state;
    next_pc    = pc_o;
    next_valid = pc_valid_o;
    next_trap  = 1'b0;
    next_bad   = bad_addr_o;
    accept     = 1'b0;
    case (state)
      BOOT: begin
        next_state = RUN;
        next_valid = 1'b1;
      end
      RUN, HOLD: begin
        if (redirect_i) begin
          // A redirect always leaves HOLD: the stalled instruction is being flushed anyway.
          accept     = 1'b1;
          next_state = RUN;
          if (is_misaligned(redirect_tgt_i)) begin
            next_pc   = TRAP_VECTOR;
            next_trap = 1'b1;
            next_bad  = redirect_tgt_i;
          end else begin
            next_pc = redirect_tgt_i;
          end
        end else if (stall_i) begin
          next_state = HOLD;
        end else begin
          next_state = RUN;
          next_pc    = pc_o + 32'(INSTR_BYTES);
        end
      end
      default: begin
        next_state = BOOT;
        next_valid = 1'b0;
      end
    endcase
  end

  // Flushes are combinational so the PC buffers clear on the same edge the new PC loads.
  assign flush_fd_o = accept & ~rst;
  assign flush_de_o = accept & ~rst;

  sat_counter #(
    .W (CNT_W)
  ) u_redirect_cnt (
    .clk (clk),
    .rst (rst),
    .inc (accept),
    .q   (redirect_cnt_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
// ---------------------------------------------------------------
// tb_pc_redirect_ctrl : directed self-checking bench for pc_redirect_ctrl
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_pc_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_tgt_i;

  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        flush_fd_o;
  logic        flush_de_o;
  logic        trap_o;
  logic [31:0] bad_addr_o;
  logic [15:0] redirect_cnt_o;

  logic [31:0] pc2;
  logic        valid2;
  logic        ffd2;
  logic        fde2;
  logic        trap2;
  logic [31:0] bad2;
  logic [1:0]  cnt2;

  int compared;
  int mismatched;

  pc_redirect_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_tgt_i (redirect_tgt_i),
    .pc_o           (pc_o),
    .pc_valid_o     (pc_valid_o),
    .flush_fd_o     (flush_fd_o),
    .flush_de_o     (flush_de_o),
    .trap_o         (trap_o),
    .bad_addr_o     (bad_addr_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  pc_redirect_ctrl #(.CNT_W(2)) dut_sat (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_tgt_i (redirect_tgt_i),
    .pc_o           (pc2),
    .pc_valid_o     (valid2),
    .flush_fd_o     (ffd2),
    .flush_de_o     (fde2),
    .trap_o         (trap2),
    .bad_addr_o     (bad2),
    .redirect_cnt_o (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_tgt_i = '0;
    repeat (3) step();
    compared++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || trap_o !== 1'b0 ||
        bad_addr_o !== 32'h0 || redirect_cnt_o !== 16'h0 || flush_fd_o !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: pc=%h valid=%b trap=%b bad=%h cnt=%h flush=%b required pc=0 valid=0 trap=0 bad=0 cnt=0 flush=0",
               pc_o, pc_valid_o, trap_o, bad_addr_o, redirect_cnt_o, flush_fd_o);
    end
    rst = 1'b0;
    #1;
    compared++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL boot_cycle: pc=%h valid=%b required pc=0 valid=0", pc_o, pc_valid_o);
    end
    step();
    compared++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b1) begin
      mismatched++;
      $display("FAIL first_valid: pc=%h valid=%b required pc=0 valid=1", pc_o, pc_valid_o);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      compared++;
      if (pc_o !== 32'(4 * i)) begin
        mismatched++;
        $display("FAIL increment_%0d: pc=%h required %h", i, pc_o, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    step();
    compared++;
    if (pc_o !== 32'h10) begin
      mismatched++;
      $display("FAIL pre_stall_pc: pc=%h required 00000010", pc_o);
    end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (pc_o !== 32'h10 || pc_valid_o !== 1'b1) begin
        mismatched++;
        $display("FAIL stall_hold_%0d: pc=%h valid=%b required pc=00000010 valid=1", i, pc_o, pc_valid_o);
      end
    end
    stall_i = 1'b0;
    step();
    compared++;
    if (pc_o !== 32'h14) begin
      mismatched++;
      $display("FAIL stall_release: pc=%h required 00000014", pc_o);
    end
  endtask

  task automatic test_redirect_over_stall();
    stall_i = 1'b1; redirect_i = 1'b1; redirect_tgt_i = 32'h200;
    #1;
    compared++;
    if (flush_fd_o !== 1'b1 || flush_de_o !== 1'b1) begin
      mismatched++;
      $display("FAIL redirect_flush: fd=%b de=%b required fd=1 de=1", flush_fd_o, flush_de_o);
    end
    step();
    redirect_i = 1'b0; stall_i = 1'b0;
    #1;
    compared++;
    if (pc_o !== 32'h200 || redirect_cnt_o !== 16'd1 || trap_o !== 1'b0 || flush_fd_o !== 1'b0) begin
      mismatched++;
      $display("FAIL redirect_target: pc=%h cnt=%0d trap=%b flush=%b required pc=00000200 cnt=1 trap=0 flush=0",
               pc_o, redirect_cnt_o, trap_o, flush_fd_o);
    end
    step();
    compared++;
    if (pc_o !== 32'h204) begin
      mismatched++;
      $display("FAIL redirect_exits_hold: pc=%h required 00000204", pc_o);
    end
  endtask

  task automatic test_misaligned();
    redirect_i = 1'b1; redirect_tgt_i = 32'h202;
    #1;
    compared++;
    if (flush_fd_o !== 1'b1 || flush_de_o !== 1'b1) begin
      mismatched++;
      $display("FAIL misalign_flush: fd=%b de=%b required fd=1 de=1", flush_fd_o, flush_de_o);
    end
    step();
    redirect_i = 1'b0;
    compared++;
    if (pc_o !== 32'h100 || trap_o !== 1'b1 || bad_addr_o !== 32'h202 || redirect_cnt_o !== 16'd2) begin
      mismatched++;
      $display("FAIL misalign_trap: pc=%h trap=%b bad=%h cnt=%0d required pc=00000100 trap=1 bad=00000202 cnt=2",
               pc_o, trap_o, bad_addr_o, redirect_cnt_o);
    end
    step();
    compared++;
    if (pc_o !== 32'h104 || trap_o !== 1'b0 || bad_addr_o !== 32'h202) begin
      mismatched++;
      $display("FAIL trap_pulse_end: pc=%h trap=%b bad=%h required pc=00000104 trap=0 bad=00000202",
               pc_o, trap_o, bad_addr_o);
    end
  endtask

  task automatic test_wrap_and_saturate();
    redirect_i = 1'b1; redirect_tgt_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    compared++;
    if (pc_o !== 32'hFFFF_FFFC || redirect_cnt_o !== 16'd3 || cnt2 !== 2'd3) begin
      mismatched++;
      $display("FAIL top_of_space: pc=%h cnt=%0d cnt2=%0d required pc=fffffffc cnt=3 cnt2=3",
               pc_o, redirect_cnt_o, cnt2);
    end
    step();
    compared++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b1) begin
      mismatched++;
      $display("FAIL pc_wrap: pc=%h valid=%b required pc=00000000 valid=1", pc_o, pc_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    redirect_i = 1'b1; redirect_tgt_i = 32'h40;
    step();
    compared++;
    if (pc_o !== 32'h40 || flush_fd_o !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_first: pc=%h flush=%b required pc=00000040 flush=1", pc_o, flush_fd_o);
    end
    redirect_tgt_i = 32'h80;
    step();
    redirect_i = 1'b0;
    compared++;
    if (pc_o !== 32'h80 || redirect_cnt_o !== 16'd5) begin
      mismatched++;
      $display("FAIL b2b_last_wins: pc=%h cnt=%0d required pc=00000080 cnt=5", pc_o, redirect_cnt_o);
    end
    compared++;
    if (cnt2 !== 2'd3) begin
      mismatched++;
      $display("FAIL counter_saturate: cnt2=%0d required 3", cnt2);
    end
  endtask

  task automatic test_reset_with_redirect();
    stall_i = 1'b1; redirect_i = 1'b1; redirect_tgt_i = 32'h302; rst = 1'b1;
    #1;
    compared++;
    if (flush_fd_o !== 1'b0 || flush_de_o !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_blocks_flush: fd=%b de=%b required fd=0 de=0", flush_fd_o, flush_de_o);
    end
    step();
    rst = 1'b0; stall_i = 1'b0; redirect_tgt_i = 32'h300;
    #1;
    compared++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || trap_o !== 1'b0 || bad_addr_o !== 32'h0 ||
        redirect_cnt_o !== 16'h0 || flush_fd_o !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_wins: pc=%h valid=%b trap=%b bad=%h cnt=%0d flush=%b required all zero",
               pc_o, pc_valid_o, trap_o, bad_addr_o, redirect_cnt_o, flush_fd_o);
    end
    step();
    redirect_i = 1'b0;
    compared++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b1 || redirect_cnt_o !== 16'h0) begin
      mismatched++;
      $display("FAIL boot_ignores_redirect: pc=%h valid=%b cnt=%0d required pc=0 valid=1 cnt=0",
               pc_o, pc_valid_o, redirect_cnt_o);
    end
    step();
    compared++;
    if (pc_o !== 32'h4) begin
      mismatched++;
      $display("FAIL post_reset_run: pc=%h required 00000004", pc_o);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_tgt_i = '0;
    test_reset();
    test_stall();
    test_redirect_over_stall();
    test_misaligned();
    test_wrap_and_saturate();
    test_back_to_back();
    test_reset_with_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
